// File: rtl/dm_cache_pkg.sv
`default_nettype none
//////////////////////////////////////////////////////////////////////////////
// dm_cache_pkg: state encoding and address-split helpers for dm_wb_cache.
// Revision: 1.0
//////////////////////////////////////////////////////////////////////////////
package dm_cache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOOKUP    = 2'd1,
    WRITEBACK = 2'd2,
    REFILL    = 2'd3
  } cache_state_t;

  function automatic int off_w(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int idx_w(input int num_lines);
    return $clog2(num_lines);
  endfunction

  function automatic int tag_w(input int addr_w, input int line_words, input int num_lines);
    return addr_w - $clog2(line_words) - $clog2(num_lines);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dm_cache_tagram.sv
`default_nettype none
//////////////////////////////////////////////////////////////////////////////
// dm_cache_tagram: tag/valid/dirty store, async read, one write port.
// Revision: 1.0
//////////////////////////////////////////////////////////////////////////////
module dm_cache_tagram #(
  parameter int TAG_W = 4,
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [TAG_W-1:0] rd_tag,
  output logic             rd_valid,
  output logic             rd_dirty,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             tag_we,
  input  logic [TAG_W-1:0] tag_wdata,
  input  logic             dirty_we,
  input  logic             dirty_wdata
);

  localparam int LINES = 1 << IDX_W;

  logic [TAG_W-1:0] tags [LINES];
  logic [LINES-1:0] valid;
  logic [LINES-1:0] dirty;

  // Only the status bits are cleared; tags are qualified by valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
      dirty <= '0;
    end else begin
      if (tag_we)   valid[wr_idx] <= 1'b1;
      if (dirty_we) dirty[wr_idx] <= dirty_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (tag_we) tags[wr_idx] <= tag_wdata;
  end

  assign rd_tag   = tags[rd_idx];
  assign rd_valid = valid[rd_idx];
  assign rd_dirty = dirty[rd_idx];

endmodule
`default_nettype wire

// File: rtl/dm_wb_cache.sv
`default_nettype none
//////////////////////////////////////////////////////////////////////////////
// dm_wb_cache: direct-mapped write-back write-allocate cache.
// Optional macro CACHE_STATS_EN adds hit/miss/write-back counters.
// Revision: 1.0
//////////////////////////////////////////////////////////////////////////////
module dm_wb_cache
  import dm_cache_pkg::*;
#(
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 16,
  parameter int LINE_WORDS = 8,
  parameter int NUM_LINES  = 256
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                cpu_req,
  input  logic                                cpu_we,
  input  logic [ADDR_W-1:0]                   cpu_addr,
  input  logic [DATA_W-1:0]                   cpu_wdata,
  output logic                                cpu_ready,
  output logic                                cpu_resp_valid,
  output logic [DATA_W-1:0]                   cpu_rdata,
  output logic                                mem_req,
  output logic                                mem_we,
  output logic [ADDR_W-off_w(LINE_WORDS)-1:0] mem_addr,
  output logic [DATA_W*LINE_WORDS-1:0]        mem_wdata,
  input  logic [DATA_W*LINE_WORDS-1:0]        mem_rdata,
  input  logic                                mem_ack
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]                         hit_cnt,
  output logic [31:0]                         miss_cnt,
  output logic [31:0]                         wb_cnt
`endif
);

  localparam int OFF_W  = off_w(LINE_WORDS);
  localparam int IDX_W  = idx_w(NUM_LINES);
  localparam int TAG_W  = tag_w(ADDR_W, LINE_WORDS, NUM_LINES);
  localparam int LINE_W = DATA_W * LINE_WORDS;

  cache_state_t state, state_nxt;

  logic [ADDR_W-1:0] req_addr;
  logic              req_we;
  logic [DATA_W-1:0] req_wdata;
  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [OFF_W-1:0]  req_off;

  assign req_tag = req_addr[ADDR_W-1 -: TAG_W];
  assign req_idx = req_addr[OFF_W +: IDX_W];
  assign req_off = req_addr[OFF_W-1:0];

  logic [TAG_W-1:0] tag_q;
  logic             valid_q, dirty_q, hit;
  logic             tag_we, dirty_we, dirty_wdata;

  dm_cache_tagram #(
    .TAG_W (TAG_W),
    .IDX_W (IDX_W)
  ) u_tagram (
    .clk         (clk),
    .rst         (rst),
    .rd_idx      (req_idx),
    .rd_tag      (tag_q),
    .rd_valid    (valid_q),
    .rd_dirty    (dirty_q),
    .wr_idx      (req_idx),
    .tag_we      (tag_we),
    .tag_wdata   (req_tag),
    .dirty_we    (dirty_we),
    .dirty_wdata (dirty_wdata)
  );

  assign hit = valid_q && (tag_q == req_tag);

  logic [LINE_W-1:0] data_mem [NUM_LINES];
  logic [LINE_W-1:0] line, merged_line, data_wline;
  logic [DATA_W-1:0] line_word [LINE_WORDS];
  logic              data_we, resp_set;

  assign line = data_mem[req_idx];

  // Word view of the indexed line plus the line with the pending write merged in.
  for (genvar w = 0; w < LINE_WORDS; w++) begin : g_word
    assign line_word[w] = line[w*DATA_W +: DATA_W];
    assign merged_line[w*DATA_W +: DATA_W] = (req_off == OFF_W'(w)) ? req_wdata : line_word[w];
  end

  always_ff @(posedge clk) begin
    if (data_we) data_mem[req_idx] <= data_wline;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    tag_we      = 1'b0;
    dirty_we    = 1'b0;
    dirty_wdata = 1'b0;
    data_we     = 1'b0;
    data_wline  = merged_line;
    resp_set    = 1'b0;
    cpu_ready   = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    case (state)
      IDLE: begin
        cpu_ready = 1'b1;
        if (cpu_req) state_nxt = LOOKUP;
      end
      LOOKUP: begin
        if (hit) begin
          resp_set  = 1'b1;
          state_nxt = IDLE;
          if (req_we) begin
            data_we     = 1'b1;
            dirty_we    = 1'b1;
            dirty_wdata = 1'b1;
          end
        end else if (valid_q && dirty_q) begin
          state_nxt = WRITEBACK;
        end else begin
          state_nxt = REFILL;
        end
      end
      WRITEBACK: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {tag_q, req_idx};
        mem_wdata = line;
        if (mem_ack) begin
          dirty_we  = 1'b1;
          state_nxt = REFILL;
        end
      end
      REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {req_tag, req_idx};
        if (mem_ack) begin
          tag_we     = 1'b1;
          dirty_we   = 1'b1;
          data_we    = 1'b1;
          data_wline = mem_rdata;
          state_nxt  = LOOKUP;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_addr       <= '0;
      req_we         <= 1'b0;
      req_wdata      <= '0;
      cpu_resp_valid <= 1'b0;
      cpu_rdata      <= '0;
    end else begin
      cpu_resp_valid <= resp_set;
      if (resp_set && !req_we) cpu_rdata <= line_word[req_off];
      if (state == IDLE && cpu_req) begin
        req_addr  <= cpu_addr;
        req_we    <= cpu_we;
        req_wdata <= cpu_wdata;
      end
    end
  end

`ifdef CACHE_STATS_EN
  // The LOOKUP that follows a refill is a retry and is not counted.
  logic retry;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retry    <= 1'b0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
      wb_cnt   <= '0;
    end else begin
      if (state == REFILL && mem_ack) retry <= 1'b1;
      else if (state == LOOKUP)       retry <= 1'b0;
      if (state == LOOKUP && !retry) begin
        if (hit && hit_cnt != '1)        hit_cnt  <= hit_cnt + 32'd1;
        else if (!hit && miss_cnt != '1) miss_cnt <= miss_cnt + 32'd1;
      end
      if (state == WRITEBACK && mem_ack && wb_cnt != '1) wb_cnt <= wb_cnt + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_dm_wb_cache.sv
`default_nettype none
//////////////////////////////////////////////////////////////////////////////
// tb_dm_wb_cache: table-driven, scoreboarded bench with a line memory model.
// Revision: 1.0
//////////////////////////////////////////////////////////////////////////////
module tb_dm_wb_cache;

  localparam int ADDR_W = 15, DATA_W = 16, LINE_WORDS = 8, NUM_LINES = 256;
  localparam int LA_W = 12, LINE_W = DATA_W * LINE_WORDS;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cpu_req = 1'b0, cpu_we = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [DATA_W-1:0] cpu_wdata = '0;
  logic              cpu_ready, cpu_resp_valid;
  logic [DATA_W-1:0] cpu_rdata;
  logic              mem_req, mem_we, mem_ack;
  logic [LA_W-1:0]   mem_addr;
  logic [LINE_W-1:0] mem_wdata, mem_rdata;
`ifdef CACHE_STATS_EN
  logic [31:0]       hit_cnt, miss_cnt, wb_cnt;
`endif

  always #5 clk = ~clk;

  dm_wb_cache #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_WORDS(LINE_WORDS), .NUM_LINES(NUM_LINES)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_resp_valid(cpu_resp_valid), .cpu_rdata(cpu_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
`ifdef CACHE_STATS_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
`endif
  );

  logic [LINE_W-1:0] mem_model [1 << LA_W];
  int                lat = 2;
  int                rf_count = 0, wb_count = 0;
  logic [LA_W-1:0]   last_rf_addr = '0, last_wb_addr = '0;
  logic [LINE_W-1:0] last_wb_data = '0;
  int                total = 0, bad = 0;
  logic [DATA_W-1:0] sb_q [$];

  function automatic logic [DATA_W-1:0] init_word(input logic [ADDR_W-1:0] a);
    return {1'b0, a} ^ 16'hC3C3;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Line memory: acks every request after lat cycles of mem_req.
  initial begin
    int cnt;
    cnt       = 0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (rst || !mem_req) cnt = 0;
      else begin
        cnt++;
        if (cnt >= lat) begin
          cnt     = 0;
          mem_ack = 1'b1;
          if (mem_we) begin
            mem_model[mem_addr] = mem_wdata;
            wb_count++;
            last_wb_addr = mem_addr;
            last_wb_data = mem_wdata;
          end else begin
            mem_rdata = mem_model[mem_addr];
            rf_count++;
            last_rf_addr = mem_addr;
          end
        end
      end
    end
  end

  task automatic do_req(input bit we, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wd,
                        input logic [DATA_W-1:0] exp, output int n);
    int t;
    logic [DATA_W-1:0] e;
    t = 0;
    while (!cpu_ready && t < 100) begin @(posedge clk); #1; t++; end
    if (!cpu_ready) begin check("ready_timeout", 32'(cpu_ready), 1); n = -1; return; end
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    sb_q.push_back(exp);
    @(posedge clk); #1;
    cpu_req = 1'b0;
    n = 0;
    while (!cpu_resp_valid && n < 200) begin @(posedge clk); #1; n++; end
    if (!cpu_resp_valid) begin check("resp_timeout", 32'(cpu_resp_valid), 1); n = -1; return; end
    check("ready_at_resp", 32'(cpu_ready), 1);
    check("sb_depth", sb_q.size(), 1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      if (!we) check("rdata", 32'(cpu_rdata), 32'(e));
    end
  endtask

  typedef struct {
    bit              we;
    logic [14:0]     addr;
    logic [15:0]     wdata;
    logic [15:0]     exp_rdata;
    int              exp_n;
    bit              exp_rf;
    logic [LA_W-1:0] exp_rf_addr;
    bit              exp_wb;
    logic [LA_W-1:0] exp_wb_addr;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int n, rf0, wb0, seen;
    for (int l = 0; l < (1 << LA_W); l++)
      for (int w = 0; w < LINE_WORDS; w++)
        mem_model[l][w*DATA_W +: DATA_W] = init_word(ADDR_W'(l * LINE_WORDS + w));
    for (int w = 0; w < LINE_WORDS; w++)
      mem_model[2][w*DATA_W +: DATA_W] = 16'hA000 + 16'(w);

    vecs[0] = '{0, 15'h0010, 16'h0000, 16'hA000,            4, 1, 12'h002, 0, 12'h000};
    vecs[1] = '{1, 15'h0013, 16'h1234, 16'h0000,            1, 0, 12'h000, 0, 12'h000};
    vecs[2] = '{0, 15'h0013, 16'h0000, 16'h1234,            1, 0, 12'h000, 0, 12'h000};
    vecs[3] = '{0, 15'h0813, 16'h0000, init_word(15'h0813), 6, 1, 12'h102, 1, 12'h002};
    vecs[4] = '{0, 15'h0013, 16'h0000, 16'h1234,            4, 1, 12'h002, 0, 12'h000};
    vecs[5] = '{1, 15'h7FFF, 16'hBEEF, 16'h0000,            4, 1, 12'hFFF, 0, 12'h000};
    vecs[6] = '{0, 15'h7FFF, 16'h0000, 16'hBEEF,            1, 0, 12'h000, 0, 12'h000};
    vecs[7] = '{0, 15'h7FF8, 16'h0000, init_word(15'h7FF8), 1, 0, 12'h000, 0, 12'h000};
    vecs[8] = '{0, 15'h07FF, 16'h0000, init_word(15'h07FF), 6, 1, 12'h0FF, 1, 12'hFFF};

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(cpu_ready), 1);
    check("rst_resp_valid", 32'(cpu_resp_valid), 0);
    check("rst_rdata", 32'(cpu_rdata), 0);
    check("rst_mem_req", 32'(mem_req), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      rf0 = rf_count; wb0 = wb_count;
      do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, n);
      check($sformatf("latency[%0d]", i), n, vecs[i].exp_n);
      check($sformatf("refills[%0d]", i), rf_count - rf0, 32'(vecs[i].exp_rf));
      check($sformatf("writebacks[%0d]", i), wb_count - wb0, 32'(vecs[i].exp_wb));
      if (vecs[i].exp_rf) check($sformatf("rf_addr[%0d]", i), 32'(last_rf_addr), 32'(vecs[i].exp_rf_addr));
      if (vecs[i].exp_wb) check($sformatf("wb_addr[%0d]", i), 32'(last_wb_addr), 32'(vecs[i].exp_wb_addr));
      if (i == 3) begin
        check("wb_word3", 32'(last_wb_data[3*DATA_W +: DATA_W]), 32'h1234);
        check("wb_word0", 32'(last_wb_data[0 +: DATA_W]), 32'hA000);
`ifdef CACHE_STATS_EN
        check("hit_cnt", hit_cnt, 2);
        check("miss_cnt", miss_cnt, 2);
        check("wb_cnt", wb_cnt, 1);
`endif
      end
      if (i == 8) check("wb_word7", 32'(last_wb_data[7*DATA_W +: DATA_W]), 32'hBEEF);
    end

    // Reset while a refill is outstanding.
    lat = 8;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0020;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    n = 0;
    while (!mem_req && n < 10) begin @(posedge clk); #1; n++; end
    check("abort_mem_req", 32'(mem_req), 1);
    check("abort_mem_we", 32'(mem_we), 0);
    check("abort_mem_addr", 32'(mem_addr), 32'h004);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_req_drop", 32'(mem_req), 0);
    check("abort_ready", 32'(cpu_ready), 1);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (cpu_resp_valid) seen++;
    end
    check("abort_no_resp", seen, 0);

    lat = 2;
    rf0 = rf_count;
    do_req(0, 15'h0020, 16'h0, init_word(15'h0020), n);
    check("refetch_latency", n, 4);
    check("refetch_count", rf_count - rf0, 1);
    do_req(0, 15'h0010, 16'h0, 16'hA000, n);
    check("cold_after_rst_latency", n, 4);
    do_req(0, 15'h0013, 16'h0, 16'h1234, n);
    check("b2b_hit_latency", n, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dm_wb_cache.md
Name: dm_wb_cache

Overview:
- Parametrised direct-mapped, write-back, write-allocate cache with a request/ready CPU port and a line-wide request/acknowledge memory port.
- Successor to the fixed 16-bit split I/D cache. Geometry is set by parameters. A real miss FSM performs dirty-victim write-back before refill, so memory is never updated as a side effect of a hit.
- The core instantiates one copy for instructions and one for data, between the pipeline and main memory.

Parameters:
ADDR_W, 15, word address width
DATA_W, 16, word width in bits
LINE_WORDS, 8, words per line (power of 2, >=2)
NUM_LINES, 256, number of lines (power of 2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
cpu_req  in  1  request valid, sampled only when cpu_ready=1
cpu_we  in  1  1=write, 0=read
cpu_addr  in  ADDR_W  word address
cpu_wdata  in  DATA_W  write word
cpu_ready  out  1  high only in IDLE
cpu_resp_valid  out  1  one-cycle pulse, request complete
cpu_rdata  out  DATA_W  read word, valid with cpu_resp_valid
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  1=line write-back, 0=line fetch
mem_addr  out  ADDR_W-OFF_W  line address {tag,index}
mem_wdata  out  DATA_W*LINE_WORDS  victim line, word 0 in LSBs
mem_rdata  in  DATA_W*LINE_WORDS  refill line
mem_ack  in  1  single-cycle completion pulse

Behaviour:
- Address split: OFF_W=log2(LINE_WORDS), IDX_W=log2(NUM_LINES), TAG_W=ADDR_W-IDX_W-OFF_W. Defaults give tag=addr[14:11], index=addr[10:3], offset=addr[2:0].
- Reset (asynchronous): all valid and dirty bits are cleared. State goes to IDLE. Every output is 0 except cpu_ready, which is 1. Tag and data arrays are not reset.
- States: IDLE, LOOKUP, WRITEBACK, REFILL.
- IDLE:
  - cpu_req=1 latches addr, we and wdata, then moves to LOOKUP.
  - cpu_req=0 stays in IDLE.
- LOOKUP: hit = valid[idx] && tag[idx]==req_tag.
  - Hit, read: cpu_rdata gets the word; cpu_resp_valid pulses; go to IDLE.
  - Hit, write: the word is written; dirty set; cpu_resp_valid pulses; go to IDLE.
  - Miss with valid && dirty: go to WRITEBACK.
  - Otherwise miss: go to REFILL.
- WRITEBACK: mem_req=1, mem_we=1, mem_addr={tag[idx],idx}, mem_wdata=line[idx]. On mem_ack, go to REFILL and clear dirty.
- REFILL: mem_req=1, mem_we=0, mem_addr={req_tag,idx}. On mem_ack, capture mem_rdata into line[idx], write tag, set valid, clear dirty, and return to LOOKUP. The retry then hits.
- Latency:
  - Hit: response in the 2nd cycle after acceptance.
  - Clean miss: acceptance + 1 + refill cycles + 2.
  - Dirty miss: adds the write-back cycles.
- cpu_resp_valid coincides with IDLE, so cpu_ready is high in the same cycle. Back-to-back requests give one request every 2 cycles on hits.
- mem_req deasserts the cycle after mem_ack. mem_ack outside WRITEBACK/REFILL is ignored.
- A write miss allocates: the line is fetched, then the word is merged in the LOOKUP retry, leaving the line dirty.
- Two different addresses mapping to the same index evict each other.
- Reset mid-miss abandons the transaction: mem_req drops asynchronously and no cpu_resp_valid is produced. The memory side must tolerate an abandoned request.
- cpu_req while cpu_ready=0 is ignored; the requester holds it.

Optional Feature:
- CACHE_STATS_EN: adds output ports hit_cnt, miss_cnt and wb_cnt, each 32 bits.
  - hit_cnt increments on a first-pass LOOKUP hit.
  - miss_cnt increments on a first-pass LOOKUP miss.
  - wb_cnt increments on a WRITEBACK mem_ack.
  - The counters saturate at 2^32-1 and reset to 0.
- The retry LOOKUP after a refill is not counted as a hit.
- Without the macro, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package dm_cache_pkg holds:
  - The state enum cache_state_t (IDLE, LOOKUP, WRITEBACK, REFILL).
  - Width helper functions for OFF_W, IDX_W and TAG_W.
- One sub-module, dm_cache_tagram: tag, valid and dirty arrays with a read port, a write port, and asynchronous clear of valid and dirty.
- The data array stays in the top level.

Test Plan:
1. Reset, then read 0x0010 with mem_rdata word0..7 = 0xA000..0xA007 → REFILL with mem_addr=0x002; on the next cycle after return, cpu_rdata=0xA000 with cpu_resp_valid; no WRITEBACK.
2. Write 0x0013=0x1234, then read 0x0013 → write hits (response 2 cycles after acceptance); read returns 0x1234; mem_req stays 0 throughout.
3. After scenario 2, read 0x0813 (same index, tag 1) → WRITEBACK with mem_addr=0x002 and mem_wdata word3=0x1234, then REFILL with mem_addr=0x102.
4. Write miss to 0x7FFF=0xBEEF on a clean invalid line → REFILL only, for line address 0xFFF; a follow-up read returns 0xBEEF with no memory traffic.
5. Assert rst while REFILL is waiting for mem_ack → mem_req=0 immediately, no response, cpu_ready=1; a re-read of the same address refetches.
6. With CACHE_STATS_EN, run scenarios 1–3 → hit_cnt=2, miss_cnt=2, wb_cnt=1.
